// File: rtl/q1_seq_pkg.sv
// Shared types for the q1 microprogram sequencer: FSM states, program entry layout
// and datapath select/operation widths.
package q1_seq_pkg;

  localparam int OP_W   = 2;
  localparam int CSEL_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic              last;
    logic              halt_on_status;
    logic [CSEL_W-1:0] const_sel;
    logic [OP_W-1:0]   op;
  } prog_entry_t;

  localparam int PROG_W = $bits(prog_entry_t);

endpackage

// File: rtl/q1_seq_prog_ram.sv
// Program store for q1_sequencer: DEPTH entries, one synchronous write port and one
// asynchronous read port. Contents are deliberately left uninitialised by reset.
module q1_seq_prog_ram
  import q1_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  prog_entry_t              wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output prog_entry_t              rdata
);

  prog_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/q1_sequencer.sv
// q1_sequencer: runs the stored (const_sel, op) microprogram through the q1 datapath,
// feeding each result back as the next operand. Optional macro SINGLE_STEP_EN adds a step gate.
module q1_sequencer
  import q1_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
`ifdef SINGLE_STEP_EN
  input  logic                     step,
`endif
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [PROG_W-1:0]        prog_data,
  input  logic                     start,
  input  logic [WIDTH-1:0]         operand,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         result,
  output logic                     halted,
  output logic [WIDTH-1:0]         dp_input,
  output logic [CSEL_W-1:0]        dp_const_sel,
  output logic [OP_W-1:0]          dp_operation,
  input  logic [WIDTH-1:0]         dp_output,
  input  logic                     dp_status,
  output state_t                   dbg_state
);

  localparam int AW = $clog2(DEPTH);

  state_t          state_q;
  logic [AW-1:0]   pc_q;
  logic [WIDTH-1:0] acc_q;
  logic            busy_q;
  logic            done_q;
  logic            halted_q;
  logic [WIDTH-1:0] result_q;

  prog_entry_t     entry;
  logic            ram_we;
  logic            step_ok;
  logic            status_halt;
  logic            is_last;
  logic            stop;

  assign ram_we = prog_we && (state_q == IDLE);

  q1_seq_prog_ram #(
    .DEPTH(DEPTH)
  ) u_prog_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (prog_addr),
    .wdata (prog_entry_t'(prog_data)),
    .raddr (pc_q),
    .rdata (entry)
  );

`ifdef SINGLE_STEP_EN
  assign step_ok = step;
`else
  assign step_ok = 1'b1;
`endif

  // The last program slot always terminates the run; the pc never wraps.
  assign status_halt = entry.halt_on_status && dp_status;
  assign is_last     = entry.last || (pc_q == AW'(DEPTH - 1));
  assign stop        = is_last || status_halt;

  // Handshake: start is sampled only in IDLE together with operand; busy covers the
  // RUN cycles; done pulses for exactly one cycle with result/halted already valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      halted_q <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q    <= operand;
            pc_q     <= '0;
            halted_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (step_ok) begin
            acc_q <= dp_output;
            if (stop) begin
              result_q <= dp_output;
              halted_q <= status_halt;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              pc_q <= pc_q + AW'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Outside RUN the datapath is parked at input 0, select 0, op 0.
  assign dp_input     = (state_q == RUN) ? acc_q : '0;
  assign dp_const_sel = (state_q == RUN) ? entry.const_sel : '0;
  assign dp_operation = (state_q == RUN) ? entry.op : '0;

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign halted    = halted_q;
  assign dbg_state = state_q;

endmodule
